// File: rtl/fb_memstage_if.sv
// Data-memory bus between the Firebird MEM stage and the data memory.
// It uses a req/gnt handshake for the address phase and rvalid for load data.
interface fb_memstage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/fb_memstage.sv
// Firebird MEM stage: word loads and stores over the dmem bus, a stall while
// an access is outstanding, an abort on timeout, branch resolution and the
// MEM/WB pipeline register.
module fb_memstage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_mem_read,
  input  logic                mem_mem_write,
  input  logic                mem_mem_to_reg,
  input  logic                mem_reg_write,
  input  logic [XLEN-1:0]     mem_alu_res,
  input  logic [XLEN-1:0]     mem_rs2_data,
  input  logic [4:0]          mem_register_rd,
  input  logic                mem_branch,
  input  logic [XLEN-1:0]     mem_pc,
  input  logic [XLEN-1:0]     mem_imm,
  input  logic [5:0]          mem_bra_control,
  fb_memstage_if.master       dmem,
  output logic                mem_stall,
  output logic                branch_taken,
  output logic [XLEN-1:0]     branch_target,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [XLEN-1:0]     wb_alu_res,
  output logic [XLEN-1:0]     wb_rdata,
  output logic [4:0]          wb_register_rd,
  output logic                bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic access, misaligned, aligned;
  logic complete, abort, load_done;
  logic req_c, stall_c, taken_c;
  logic bra_onehot;

  // Bus outputs follow the instruction held in EX/MEM; upstream keeps it stable while stalled.
  assign dmem.dmem_addr  = mem_alu_res;
  assign dmem.dmem_wdata = mem_rs2_data;
  assign dmem.dmem_we    = mem_mem_write;
  assign branch_target   = mem_pc + mem_imm;

  // Access classification, completion/abort detection and next-state logic.
  always_comb begin
    access     = mem_mem_read | mem_mem_write;
    misaligned = access & (mem_alu_res[1:0] != 2'b00);
    aligned    = access & ~misaligned;
    complete   = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE:    complete = aligned & mem_mem_write & dmem.dmem_gnt;
      REQ:     complete = mem_mem_write & dmem.dmem_gnt;
      WAIT:    complete = dmem.dmem_rvalid;
      default: complete = 1'b0;
    endcase
    abort     = (state != IDLE) & (cnt == CNT_LAST) & ~complete;
    load_done = (state == WAIT) & dmem.dmem_rvalid;
    req_c     = ((state == IDLE) & aligned) | (state == REQ);
    stall_c   = (((state == IDLE) & aligned) | (state != IDLE)) & ~complete & ~abort;
    case (state)
      IDLE: begin
        if (aligned) begin
          if (dmem.dmem_gnt) state_nxt = mem_mem_write ? IDLE : WAIT;
          else               state_nxt = REQ;
        end
      end
      REQ: begin
        if (abort)               state_nxt = IDLE;
        else if (dmem.dmem_gnt)  state_nxt = mem_mem_write ? IDLE : WAIT;
      end
      WAIT: begin
        if (dmem.dmem_rvalid | abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Branch condition: only a single-hot compare selector can redirect.
  always_comb begin
    bra_onehot = (mem_bra_control != 6'd0) &&
                 ((mem_bra_control & (mem_bra_control - 6'd1)) == 6'd0);
    taken_c = mem_branch & bra_onehot &
              ((mem_bra_control[0] & (mem_alu_res == '0)) |
               (mem_bra_control[1] & (mem_alu_res != '0)) |
               ((mem_bra_control[2] | mem_bra_control[4]) & mem_alu_res[0]) |
               ((mem_bra_control[3] | mem_bra_control[5]) & ~mem_alu_res[0]));
  end

  // Combinational outputs are forced low while reset is held.
  assign dmem.dmem_req = rst & req_c;
  assign mem_stall     = rst & stall_c;
  assign branch_taken  = rst & taken_c;

  // Access FSM and outstanding-access timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || state_nxt == IDLE) cnt <= '0;
      else                                    cnt <= cnt + CNT_W'(1);
    end
  end

  // MEM/WB register: a bubble while stalled, with writeback suppressed on misaligned or aborted accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_alu_res     <= '0;
      wb_rdata       <= '0;
      wb_register_rd <= '0;
      bus_err        <= 1'b0;
    end else begin
      bus_err <= misaligned | abort;
      if (stall_c) begin
        wb_reg_write <= 1'b0;
      end else begin
        wb_reg_write   <= mem_reg_write & ~misaligned & ~abort;
        wb_mem_to_reg  <= mem_mem_to_reg;
        wb_alu_res     <= mem_alu_res;
        wb_register_rd <= mem_register_rd;
      end
      if (abort)          wb_rdata <= '0;
      else if (load_done) wb_rdata <= dmem.dmem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_memstage.sv
// Directed bench for fb_memstage: stores, loads with wait states, misaligned
// access, timeout abort, branch resolution and reset during an access.
module tb_fb_memstage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [XLEN-1:0] mem_alu_res, mem_rs2_data, mem_pc, mem_imm;
  logic [4:0]      mem_register_rd;
  logic            mem_branch;
  logic [5:0]      mem_bra_control;
  logic            mem_stall, branch_taken, wb_reg_write, wb_mem_to_reg, bus_err;
  logic [XLEN-1:0] branch_target, wb_alu_res, wb_rdata;
  logic [4:0]      wb_register_rd;

  int n_chk  = 0;
  int n_pass = 0;
  int n_stall;

  fb_memstage_if #(.XLEN(XLEN)) dmem ();

  fb_memstage #(.XLEN(XLEN), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_alu_res(mem_alu_res), .mem_rs2_data(mem_rs2_data),
    .mem_register_rd(mem_register_rd), .mem_branch(mem_branch),
    .mem_pc(mem_pc), .mem_imm(mem_imm), .mem_bra_control(mem_bra_control),
    .dmem(dmem.master),
    .mem_stall(mem_stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_res(wb_alu_res), .wb_rdata(wb_rdata),
    .wb_register_rd(wb_register_rd), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_mem_read = 0; mem_mem_write = 0; mem_mem_to_reg = 0; mem_reg_write = 0;
    mem_alu_res = '0; mem_rs2_data = '0; mem_register_rd = '0;
    mem_branch = 0; mem_pc = '0; mem_imm = '0; mem_bra_control = '0;
    dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    clear_in();
    // Reset: registered outputs clear and combinational outputs are held low.
    mem_mem_read = 1; mem_alu_res = 32'h40;
    mem_branch = 1; mem_bra_control = 6'b000010;
    #2;
    check("rst_req", dmem.dmem_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_taken", branch_taken, 0);
    check("rst_wb_rw", wb_reg_write, 0);
    check("rst_wb_alu", wb_alu_res, 0);
    check("rst_bus_err", bus_err, 0);
    clear_in();
    #10 rst = 1;
    cyc();

    // Store granted in the same cycle.
    mem_mem_write = 1; mem_alu_res = 32'h100; mem_rs2_data = 32'hDEADBEEF;
    mem_reg_write = 1; mem_register_rd = 5'd3; dmem.dmem_gnt = 1;
    #1;
    check("st_req", dmem.dmem_req, 1);
    check("st_we", dmem.dmem_we, 1);
    check("st_addr", dmem.dmem_addr, 32'h100);
    check("st_wdata", dmem.dmem_wdata, 32'hDEADBEEF);
    check("st_stall", mem_stall, 0);
    cyc();
    check("st_wb_rw", wb_reg_write, 1);
    check("st_wb_alu", wb_alu_res, 32'h100);
    check("st_wb_rd", wb_register_rd, 3);
    clear_in();
    #1 check("st_req_drop", dmem.dmem_req, 0);

    // Load at 0x40: gnt in cycle 2, rvalid in cycle 5.
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_alu_res = 32'h40; mem_register_rd = 5'd5;
    for (int k = 0; k <= 5; k++) begin
      dmem.dmem_gnt = (k == 2);
      dmem.dmem_rvalid = (k == 5);
      dmem.dmem_rdata = (k == 5) ? 32'hCAFEF00D : 32'h0;
      #1;
      check($sformatf("ld_stall%0d", k), mem_stall, (k < 5) ? 1 : 0);
      check($sformatf("ld_req%0d", k), dmem.dmem_req, (k <= 2) ? 1 : 0);
      cyc();
      if (k < 5) begin
        check($sformatf("ld_bubble%0d", k), wb_reg_write, 0);
        check($sformatf("ld_hold_alu%0d", k), wb_alu_res, 32'h100);
      end
    end
    check("ld_wb_rw", wb_reg_write, 1);
    check("ld_wb_rdata", wb_rdata, 32'hCAFEF00D);
    check("ld_wb_m2r", wb_mem_to_reg, 1);
    check("ld_wb_rd", wb_register_rd, 5);
    clear_in();

    // Misaligned load: no request, no stall, error pulse, no writeback.
    mem_mem_read = 1; mem_alu_res = 32'h42; mem_reg_write = 1; mem_register_rd = 5'd7;
    #1;
    check("mis_req", dmem.dmem_req, 0);
    check("mis_stall", mem_stall, 0);
    cyc();
    check("mis_bus_err", bus_err, 1);
    check("mis_wb_rw", wb_reg_write, 0);
    clear_in();
    cyc();
    check("mis_err_pulse", bus_err, 0);

    // Load granted immediately but rvalid never arrives: 16 stall cycles then abort.
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_alu_res = 32'h80; mem_register_rd = 5'd9; dmem.dmem_gnt = 1;
    n_stall = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!mem_stall) break;
      n_stall++;
      cyc();
      dmem.dmem_gnt = 0;
    end
    check("to_stall_cycles", n_stall, 16);
    cyc();
    clear_in();
    check("to_bus_err", bus_err, 1);
    check("to_wb_rw", wb_reg_write, 0);
    check("to_wb_rdata", wb_rdata, 0);
    // Late rvalid for the aborted load must be ignored.
    dmem.dmem_rvalid = 1; dmem.dmem_rdata = 32'h12345678;
    cyc();
    check("to_err_pulse", bus_err, 0);
    check("to_late_rdata", wb_rdata, 0);
    clear_in();
    // Next load completes normally.
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_alu_res = 32'h44; mem_register_rd = 5'd10; dmem.dmem_gnt = 1;
    #1 check("nx_stall0", mem_stall, 1);
    cyc();
    dmem.dmem_gnt = 0; dmem.dmem_rvalid = 1; dmem.dmem_rdata = 32'h0BADF00D;
    #1 check("nx_stall1", mem_stall, 0);
    cyc();
    check("nx_wb_rdata", wb_rdata, 32'h0BADF00D);
    check("nx_wb_rw", wb_reg_write, 1);
    clear_in();

    // Branch resolution (combinational, never stalls).
    mem_branch = 1; mem_bra_control = 6'b000010; mem_alu_res = 32'd5;
    mem_pc = 32'h200; mem_imm = 32'hFFFFFFF8;
    #1;
    check("bne_taken", branch_taken, 1);
    check("bne_target", branch_target, 32'h1F8);
    check("br_stall", mem_stall, 0);
    mem_bra_control = 6'b001000; mem_alu_res = 32'd1;
    #1 check("bge_taken", branch_taken, 0);
    mem_bra_control = 6'b000000; mem_alu_res = 32'd0;
    #1 check("zero_ctl_taken", branch_taken, 0);
    mem_bra_control = 6'b000001;
    #1 check("beq_taken", branch_taken, 1);
    mem_bra_control = 6'b000011;
    #1 check("multihot_taken", branch_taken, 0);
    mem_bra_control = 6'b000100; mem_alu_res = 32'd1;
    #1 check("blt_taken", branch_taken, 1);
    mem_branch = 0;
    #1 check("nobranch_taken", branch_taken, 0);
    mem_pc = 32'hFFFFFFFC; mem_imm = 32'd8;
    #1 check("target_wrap", branch_target, 32'h4);
    clear_in();
    cyc();

    // Reset asserted while a load is in WAIT.
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_alu_res = 32'h60; mem_register_rd = 5'd11; dmem.dmem_gnt = 1;
    cyc();
    dmem.dmem_gnt = 0;
    #1;
    check("rw_wait_req", dmem.dmem_req, 0);
    check("rw_wait_stall", mem_stall, 1);
    rst = 0;
    #1;
    check("rw_rst_req", dmem.dmem_req, 0);
    check("rw_rst_stall", mem_stall, 0);
    check("rw_rst_rdata", wb_rdata, 0);
    check("rw_rst_rd", wb_register_rd, 0);
    check("rw_rst_m2r", wb_mem_to_reg, 0);
    #2 rst = 1;
    clear_in();
    cyc();
    dmem.dmem_rvalid = 1; dmem.dmem_rdata = 32'hA5A5A5A5;
    cyc();
    check("rw_late_rdata", wb_rdata, 0);
    check("rw_late_rw", wb_reg_write, 0);
    clear_in();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
